// File: rtl/program_loader.sv
// program_loader: assembles big-endian bytes from a serial receiver into
// 32-bit instruction words, writes them sequentially into instruction memory
// and holds the pipeline disabled (cpu_enable=0) until the load completes.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// after the terminator word (CHK state); undefined, the terminator ends the load.
module program_loader #(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_enable
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(3);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam state_t S_AFTER_TERM = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam state_t S_AFTER_TERM = S_DONE;
`endif

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [WORD_W-1:0]  word_shift_c;
    logic               term_c;
    logic               load_c;
    logic               accept_c;

    logic               rx_ready_d;
    logic               imem_we_d;
    logic               busy_d;
    logic               done_d;
    logic               error_d;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]  csum_q;
    logic [BYTE_W-1:0]  word_xor_c;
`endif

    // Candidate word if the byte on rx_data is shifted in (big-endian order)
    assign word_shift_c = {imem_wdata[WORD_W-BYTE_W-1:0], rx_data};
    assign term_c       = (word_shift_c == END_WORD);

`ifdef LOADER_CHECKSUM_EN
    // XOR of the four bytes of the word currently being written
    assign word_xor_c = imem_wdata[31:24] ^ imem_wdata[23:16]
                      ^ imem_wdata[15:8]  ^ imem_wdata[7:0];
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus load/accept strobes for the datapath
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        accept_c = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_RECV;
                    load_c  = 1'b1;
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    accept_c = 1'b1;
                    if (byte_idx_q == IDX_LAST) begin
                        state_d = term_c ? S_AFTER_TERM : S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                state_d = (imem_addr == ADDR_LAST) ? S_ERROR : S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decode of the status outputs for the state being entered
    always_comb begin
        rx_ready_d = 1'b0;
        imem_we_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_d)
            S_RECV: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_WRITE: begin
                imem_we_d = 1'b1;
                busy_d    = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
`endif
            S_DONE: begin
                done_d = 1'b1;
            end
            S_ERROR: begin
                error_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered status outputs; cpu_enable mirrors done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_enable <= 1'b0;
        end else begin
            rx_ready   <= rx_ready_d;
            imem_we    <= imem_we_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            cpu_enable <= done_d;
        end
    end

    // Word assembly, write address and written-word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            imem_wdata <= '0;
            imem_addr  <= '0;
            word_count <= '0;
        end else begin
            if (load_c) begin
                byte_idx_q <= '0;
                imem_addr  <= '0;
                word_count <= '0;
            end else if (state_q == S_WRITE) begin
                word_count <= word_count + CNT_W'(1);
                // Address saturates on the last slot; the FSM goes to ERROR there
                if (imem_addr != ADDR_LAST) begin
                    imem_addr <= imem_addr + ADDR_W'(1);
                end
            end
            if (accept_c) begin
                imem_wdata <= word_shift_c;
                byte_idx_q <= byte_idx_q + IDX_W'(1);
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR over every byte of every written word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (load_c) begin
            csum_q <= '0;
        end else if (state_q == S_WRITE) begin
            csum_q <= csum_q ^ word_xor_c;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Two instances share the byte stream:
// dut_a uses the default ADDR_W=8, dut_b uses ADDR_W=2 to exercise overflow.
// Expected memory writes are queued when a word is sent and popped by
// per-instance monitors whenever imem_we is seen high.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       a_rx_ready, a_imem_we, a_busy, a_done, a_error, a_cpu_enable;
    logic [7:0] a_imem_addr;
    logic [31:0] a_imem_wdata;
    logic [8:0] a_word_count;

    logic       b_rx_ready, b_imem_we, b_busy, b_done, b_error, b_cpu_enable;
    logic [1:0] b_imem_addr;
    logic [31:0] b_imem_wdata;
    logic [2:0] b_word_count;

    program_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(a_rx_ready), .imem_we(a_imem_we), .imem_addr(a_imem_addr),
        .imem_wdata(a_imem_wdata), .word_count(a_word_count), .busy(a_busy),
        .done(a_done), .error(a_error), .cpu_enable(a_cpu_enable)
    );

    program_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(b_rx_ready), .imem_we(b_imem_we), .imem_addr(b_imem_addr),
        .imem_wdata(b_imem_wdata), .word_count(b_word_count), .busy(b_busy),
        .done(b_done), .error(b_error), .cpu_enable(b_cpu_enable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    wr_t ea;
    wr_t eb;

    int         a_addr = 0;
    int         b_addr = 0;
    bit         b_err = 1'b0;
    logic [7:0] csum_m = 8'h00;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the ADDR_W=8 instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && a_imem_we === 1'b1) begin
            check("a_write_expected", 64'(qa.size() > 0), 64'(1));
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check("a_wr_addr", 64'(a_imem_addr), 64'(ea.addr));
                check("a_wr_data", 64'(a_imem_wdata), 64'(ea.data));
            end
        end
    end

    // Scoreboard for the ADDR_W=2 instance
    always @(negedge clk) begin
        if (rst_n === 1'b1 && b_imem_we === 1'b1) begin
            check("b_write_expected", 64'(qb.size() > 0), 64'(1));
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check("b_wr_addr", 64'(b_imem_addr), 64'(eb.addr));
                check("b_wr_data", 64'(b_imem_wdata), 64'(eb.data));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        a_addr = 0;
        b_addr = 0;
        b_err  = 1'b0;
        csum_m = 8'h00;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (a_rx_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (a_rx_ready !== 1'b1) begin
            check("rx_ready_timeout", 64'(a_rx_ready), 64'(1));
            return;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] w);
        qa.push_back({8'(a_addr), w});
        a_addr++;
        if (!b_err) begin
            qb.push_back({8'(b_addr), w});
            if (b_addr == 3) b_err = 1'b1;
            else b_addr++;
        end
        csum_m = csum_m ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endtask

    task automatic send_bytes(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) send_byte(v[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        push_exp(w);
        send_bytes(w);
        check("we_latency", 64'(a_imem_we), 64'(1));
        check("ready_low_in_write", 64'(a_rx_ready), 64'(0));
        tick();
        check("we_one_cycle", 64'(a_imem_we), 64'(0));
        check("ready_back", 64'(a_rx_ready), 64'(1));
    endtask

    task automatic send_term();
        send_bytes(32'hFFFF_FFFF);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum_m);
`endif
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_rx_ready", 64'(a_rx_ready), 64'(0));
        check("rst_imem_we", 64'(a_imem_we), 64'(0));
        check("rst_busy", 64'(a_busy), 64'(0));
        check("rst_done", 64'(a_done), 64'(0));
        check("rst_error", 64'(a_error), 64'(0));
        check("rst_cpu_enable", 64'(a_cpu_enable), 64'(0));
        check("rst_word_count", 64'(a_word_count), 64'(0));
        check("rst_imem_addr", 64'(a_imem_addr), 64'(0));
        rst_n = 1'b1;
        tick();
        check("idle_no_ready", 64'(a_rx_ready), 64'(0));

        // Single word then terminator
        pulse_start();
        check("t1_busy", 64'(a_busy), 64'(1));
        send_word(32'h0000_0020);
        send_term();
        check("t1_done", 64'(a_done), 64'(1));
        check("t1_cpu_enable", 64'(a_cpu_enable), 64'(1));
        check("t1_word_count", 64'(a_word_count), 64'(1));
        check("t1_busy_low", 64'(a_busy), 64'(0));
        check("t1_b_done", 64'(b_done), 64'(1));

        // Three words
        pulse_start();
        check("t2_cpu_enable_drop", 64'(a_cpu_enable), 64'(0));
        check("t2_done_drop", 64'(a_done), 64'(0));
        check("t2_count_clear", 64'(a_word_count), 64'(0));
        send_word(32'h8C01_0004);
        send_word(32'h0022_1820);
        send_word(32'h0800_0000);
        send_term();
        check("t2_done", 64'(a_done), 64'(1));
        check("t2_word_count", 64'(a_word_count), 64'(3));

        // Overflow on the 4-word instance after the final slot is written
        pulse_start();
        send_word(32'h1111_0001);
        send_word(32'h2222_0002);
        send_word(32'h3333_0003);
        send_word(32'h4444_0004);
        check("t3_b_error", 64'(b_error), 64'(1));
        check("t3_b_cpu_enable", 64'(b_cpu_enable), 64'(0));
        check("t3_b_word_count", 64'(b_word_count), 64'(4));
        check("t3_b_busy", 64'(b_busy), 64'(0));
        check("t3_b_rx_ready", 64'(b_rx_ready), 64'(0));
        check("t3_a_busy", 64'(a_busy), 64'(1));
        send_term();
        check("t3_a_done", 64'(a_done), 64'(1));
        check("t3_a_word_count", 64'(a_word_count), 64'(4));
        check("t3_b_still_error", 64'(b_error), 64'(1));
        pulse_start();
        check("t3_b_restart_error", 64'(b_error), 64'(0));
        check("t3_b_restart_busy", 64'(b_busy), 64'(1));
        check("t3_b_restart_addr", 64'(b_imem_addr), 64'(0));
        check("t3_b_restart_count", 64'(b_word_count), 64'(0));
        send_word(32'h2400_0001);
        send_term();
        check("t3_b_done", 64'(b_done), 64'(1));
        check("t3_b_final_count", 64'(b_word_count), 64'(1));

        // Empty program
        pulse_start();
        send_term();
        check("t4_done", 64'(a_done), 64'(1));
        check("t4_word_count", 64'(a_word_count), 64'(0));

        // Asynchronous reset in the middle of a word
        pulse_start();
        send_byte(8'hAB);
        send_byte(8'hCD);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", 64'(a_busy), 64'(0));
        check("t5_rx_ready", 64'(a_rx_ready), 64'(0));
        check("t5_wdata", 64'(a_imem_wdata), 64'(0));
        check("t5_b_busy", 64'(b_busy), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
        pulse_start();
        send_word(32'h1234_ABCD);
        send_term();
        check("t5_done", 64'(a_done), 64'(1));
        check("t5_word_count", 64'(a_word_count), 64'(1));

        // Byte during WRITE is dropped; start during RECV is ignored
        pulse_start();
        push_exp(32'h0A0B_0C0D);
        send_bytes(32'h0A0B_0C0D);
        check("t6_we", 64'(a_imem_we), 64'(1));
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        check("t6_ready_in_write", 64'(a_rx_ready), 64'(0));
        tick();
        rx_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_busy_after_start", 64'(a_busy), 64'(1));
        check("t6_count_kept", 64'(a_word_count), 64'(1));
        check("t6_addr_kept", 64'(a_imem_addr), 64'(1));
        send_word(32'h5566_7788);
        send_term();
        check("t6_done", 64'(a_done), 64'(1));
        check("t6_word_count", 64'(a_word_count), 64'(2));

`ifdef LOADER_CHECKSUM_EN
        // Checksum byte: 12^34^56^78 = 08
        pulse_start();
        send_word(32'h1234_5678);
        send_bytes(32'hFFFF_FFFF);
        check("t7_chk_busy", 64'(a_busy), 64'(1));
        send_byte(8'h08);
        check("t7_good_done", 64'(a_done), 64'(1));
        check("t7_good_error", 64'(a_error), 64'(0));
        pulse_start();
        send_word(32'h1234_5678);
        send_bytes(32'hFFFF_FFFF);
        send_byte(8'h09);
        check("t7_bad_error", 64'(a_error), 64'(1));
        check("t7_bad_done", 64'(a_done), 64'(0));
        check("t7_bad_cpu_enable", 64'(a_cpu_enable), 64'(0));
`endif

        tick();
        tick();
        check("a_queue_drained", 64'(qa.size()), 64'(0));
        check("b_queue_drained", 64'(qb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
